// File: rtl/pwm_multi_channel.sv
// rtl/pwm_multi_channel.sv - multi-channel PWM with shared period counter and shadowed config
// Edge- and center-aligned modes; shadow registers commit to the active set only at period boundaries.
module pwm_multi_channel #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 16,
  parameter int ADDR_W   = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [WIDTH-1:0]    wr_data,
  output logic [CHANNELS-1:0] pwm,
  output logic                period_tick
);

  logic               sh_en;
  logic               sh_mode;
  logic [WIDTH-1:0]   sh_period;
  logic [WIDTH-1:0]   sh_duty [CHANNELS];

  logic               act_mode;
  logic [WIDTH-1:0]   act_period;
  logic [WIDTH-1:0]   act_duty [CHANNELS];

  logic [WIDTH-1:0]   cnt;
  logic               dir_down;

  logic               idle;
  logic               at_top;
  logic               boundary;
  logic               load;
  logic [CHANNELS-1:0] cmp;

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_en     <= 1'b0;
      sh_mode   <= 1'b0;
      sh_period <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        sh_duty[i] <= '0;
      end
    end else if (wr_en) begin
      if (wr_addr == ADDR_W'(0)) begin
        sh_en   <= wr_data[0];
        sh_mode <= wr_data[1];
      end
      if (wr_addr == ADDR_W'(1)) begin
        sh_period <= wr_data;
      end
      for (int i = 0; i < CHANNELS; i++) begin
        if (wr_addr == ADDR_W'(i + 2)) begin
          sh_duty[i] <= wr_data;
        end
      end
    end
  end

  // A zero period behaves like a permanent boundary so the shadow set keeps flowing in.
  always_comb begin
    idle     = !sh_en || (act_period == '0);
    at_top   = (act_period != '0) && (cnt == act_period - WIDTH'(1));
    boundary = act_mode ? (dir_down && (cnt == '0)) : at_top;
    load     = idle || boundary;
    cmp      = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (act_duty[i] == '0) begin
        cmp[i] = 1'b0;
      end else if (act_duty[i] >= act_period) begin
        cmp[i] = 1'b1;
      end else if (act_mode) begin
        cmp[i] = (cnt >= act_period - act_duty[i]);
      end else begin
        cmp[i] = (cnt < act_duty[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      dir_down    <= 1'b0;
      act_mode    <= 1'b0;
      act_period  <= '0;
      pwm         <= '0;
      period_tick <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        act_duty[i] <= '0;
      end
    end else begin
      if (idle) begin
        cnt         <= '0;
        dir_down    <= 1'b0;
        pwm         <= '0;
        period_tick <= 1'b0;
      end else begin
        pwm         <= cmp;
        period_tick <= boundary;
        if (boundary) begin
          cnt      <= '0;
          dir_down <= 1'b0;
        end else if (!act_mode) begin
          cnt <= cnt + WIDTH'(1);
        end else if (!dir_down) begin
          // Top value is held for a second cycle while the direction flips.
          if (at_top) begin
            dir_down <= 1'b1;
          end else begin
            cnt <= cnt + WIDTH'(1);
          end
        end else begin
          cnt <= cnt - WIDTH'(1);
        end
      end
      if (load) begin
        act_mode   <= sh_mode;
        act_period <= sh_period;
        for (int i = 0; i < CHANNELS; i++) begin
          act_duty[i] <= sh_duty[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// tb/tb_pwm_multi_channel.sv - scoreboard bench for pwm_multi_channel
module tb_pwm_multi_channel;
  localparam int CH = 4;
  localparam int W  = 16;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic [CH-1:0] pwm;
  logic          period_tick;

  pwm_multi_channel #(.CHANNELS(CH), .WIDTH(W), .ADDR_W(AW)) dut (
    .clk(clk),
    .reset(reset),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .pwm(pwm),
    .period_tick(period_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic [CH-1:0] pwm;
    logic          tick;
    int            tid;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   tid   = 0;
  bit   ctr_p0 [8] = '{0, 0, 1, 1, 1, 1, 0, 0};

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every cycle the DUT presents a new output; compare all entries due now.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      mon_e = q.pop_front();
      n_cmp++;
      if (mon_e.cyc != cyc || pwm !== mon_e.pwm || period_tick !== mon_e.tick) begin
        n_bad++;
        $display("FAIL test%0d cyc %0d (due %0d): pwm=%b tick=%b expected pwm=%b tick=%b",
                 mon_e.tid, cyc, mon_e.cyc, pwm, period_tick, mon_e.pwm, mon_e.tick);
      end
    end
  end

  task automatic push(input int c, input logic [CH-1:0] p, input logic t);
    exp_t e;
    e.cyc  = c;
    e.pwm  = p;
    e.tick = t;
    e.tid  = tid;
    q.push_back(e);
  endtask

  task automatic wr(input int a, input int d);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = W'(d);
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    push(cyc, '0, 1'b0);
  endtask

  task automatic drain();
    for (int n = 0; n < 300 && q.size() > 0; n++) begin
      @(posedge clk);
      #1;
    end
    if (q.size() > 0) begin
      $display("FAIL drain: %0d expected entries never compared", q.size());
      $fatal(1);
    end
  endtask

  initial begin
    int k;
    int m;
    int r;
    logic [CH-1:0] p;
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    tid = 1;
    for (int j = 0; j < 4; j++) push(cyc + j, '0, 1'b0);
    drain();

    // Edge mode, P=10, duty0=3
    tid = 2;
    wr(1, 10); wr(2, 3); wr(0, 1);
    k = cyc;
    for (int j = 1; j <= 30; j++) begin
      p = '0;
      p[0] = ((j - 1) % 10) < 3;
      push(k + j, p, (j % 10) == 0);
    end
    drain();
    do_reset();

    // Center mode, P=4, duties 2,0,4,5
    tid = 3;
    wr(1, 4); wr(2, 2); wr(3, 0); wr(4, 4); wr(5, 5); wr(0, 2); wr(0, 3);
    k = cyc;
    for (int j = 1; j <= 24; j++) begin
      p = 4'b1100;
      p[0] = ctr_p0[(j - 1) % 8];
      push(k + j, p, (j % 8) == 0);
    end
    drain();
    do_reset();

    // Duty update mid-period
    tid = 4;
    wr(1, 8); wr(2, 2); wr(0, 1);
    k = cyc;
    for (int j = 1; j <= 16; j++) begin
      p = '0;
      p[0] = (j <= 8) ? ((j - 1) < 2) : ((j - 9) < 6);
      push(k + j, p, (j % 8) == 0);
    end
    repeat (3) @(posedge clk);
    #1;
    wr(2, 6);
    drain();
    do_reset();

    // Period write on the boundary cycle
    tid = 5;
    wr(1, 8); wr(2, 3); wr(0, 1);
    k = cyc;
    for (int j = 1; j <= 26; j++) begin
      p = '0;
      if (j <= 8)       p[0] = (j - 1) < 3;
      else if (j <= 16) p[0] = (j - 9) < 3;
      else if (j <= 21) p[0] = (j - 17) < 3;
      else              p[0] = (j - 22) < 3;
      push(k + j, p, (j == 8) || (j == 16) || (j == 21) || (j == 26));
    end
    repeat (7) @(posedge clk);
    #1;
    wr(1, 5);
    drain();
    do_reset();

    // Zero period, then PERIOD=6
    tid = 6;
    wr(2, 3); wr(0, 1);
    k = cyc;
    for (int j = 1; j <= 6; j++) push(k + j, '0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    wr(1, 6);
    m = cyc;
    push(m + 1, '0, 1'b0);
    for (int j = 1; j <= 12; j++) begin
      p = '0;
      p[0] = ((j - 1) % 6) < 3;
      push(m + 1 + j, p, (j % 6) == 0);
    end
    drain();
    do_reset();

    // Reset mid-period in center mode, then confirm shadows were cleared
    tid = 7;
    wr(1, 4); wr(2, 2); wr(3, 0); wr(4, 4); wr(5, 5); wr(0, 2); wr(0, 3);
    k = cyc;
    for (int j = 1; j <= 5; j++) begin
      p = 4'b1100;
      p[0] = ctr_p0[(j - 1) % 8];
      push(k + j, p, 1'b0);
    end
    repeat (5) @(posedge clk);
    #1;
    do_reset();
    r = cyc;
    wr(1, 4);
    for (int j = 0; j < 5; j++) push(r + 1 + j, '0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    wr(0, 1);
    k = cyc;
    for (int j = 1; j <= 8; j++) push(k + j, '0, (j % 4) == 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pwm_multi_channel.md
Name: pwm_multi_channel

Overview:
Multi-channel PWM generator with a shared programmable period counter and a per-channel programmable duty value. Supports edge-aligned and center-aligned modes. Configuration is written through a simple register write port into shadow registers. Shadow values are committed to the active registers only at period boundaries, so updates are glitch-free.

Parameters:
CHANNELS, 4, number of PWM outputs (1..16)
WIDTH, 16, width of the period, duty and counter values
ADDR_W, 5, write-address width; must satisfy 2^ADDR_W >= CHANNELS+2

Ports:
clk  input  1  system clock; all logic on the rising edge
reset  input  1  synchronous, active-high reset
wr_en  input  1  register write strobe, one write per cycle
wr_addr  input  ADDR_W  0=CTRL, 1=PERIOD, 2+i=DUTY[i]; other addresses ignored
wr_data  input  WIDTH  write data; CTRL uses bit0=enable, bit1=mode (0 edge, 1 center)
pwm  output  CHANNELS  registered PWM outputs
period_tick  output  1  one-cycle pulse, registered, marks the last cycle of each period

Behaviour:
- Reset is synchronous and active-high. On reset, all shadow and active registers are 0, the counter is 0, the direction is up, pwm is all 0, and period_tick is 0.
- Writes:
  - A write lands in the shadow register at the clock edge.
  - The enable bit takes effect on the next cycle.
  - mode, PERIOD and DUTY reach the active set only at a boundary load.
- Disabled (enable=0):
  - Counter is held at 0 and direction is up.
  - pwm is 0 and period_tick is 0.
  - The active set reloads from shadow every cycle, so the first period after enabling uses the latest values.
- Edge mode, active period P:
  - Counter runs 0..P-1 and wraps; the period is P cycles.
  - Boundary condition: cnt==P-1.
  - Compare: cnt < duty[i].
- Center mode, active period P:
  - Counter runs up 0..P-1, then down P-1..0; the period is 2P cycles. The value P-1 and the value 0 each appear twice in a row.
  - Boundary condition: direction down and cnt==0.
  - Compare: cnt >= P-duty[i], which gives 2*duty[i] high cycles centred on the turnaround.
- Saturation:
  - duty==0 keeps the output low.
  - duty >= P keeps the output high for the whole period.
- P==0:
  - Counter is held at 0 and pwm is 0.
  - The boundary condition is true every cycle, so shadow loads every cycle.
  - period_tick stays 0.
- Latency:
  - pwm[i] at cycle t+1 is the compare result of the counter value at cycle t.
  - period_tick at t+1 is high iff cycle t met the boundary condition.
- Boundary load:
  - In the cycle that meets the boundary condition, the active set loads the shadow contents as they were before that cycle's edge.
  - The counter restarts at 0 with direction up.
  - A write in that same cycle takes effect at the following boundary.
- Width rules:
  - Counter is WIDTH bits; P-duty is computed only when duty < P, so there is no underflow.
  - P-1 never wraps because P==0 is handled separately.
- Mode change: a mode write takes effect only at a boundary, and the counter restarts from 0 up in the new mode.
- Reset mid-period: applied on the next edge regardless of state; outputs are 0 on the following cycle.

Test Plan:
- Reset, then enable in edge mode with PERIOD=10 and DUTY0=3 -> pwm[0] repeats 3 high then 7 low; period_tick pulses every 10 cycles; first high appears 1 cycle after enable is seen.
- Center mode with PERIOD=4, DUTY0=2, DUTY1=0, DUTY2=4, DUTY3=5 -> counter sequence 0,1,2,3,3,2,1,0.
  - pwm[0] is low,low,high,high,high,high,low,low.
  - pwm[1] stays low.
  - pwm[2] and pwm[3] stay high.
  - period_tick every 8 cycles.
- Duty update mid-period: edge mode, PERIOD=8, DUTY0=2; write DUTY0=6 at counter value 3 -> current period keeps 2 high cycles, next period has 6 high cycles.
- Write on the boundary cycle: PERIOD=8, write PERIOD=5 in the cycle with cnt==7 -> the next period is still 8 cycles, the one after is 5.
- PERIOD=0 with enable=1 -> pwm stays 0 and period_tick stays 0; writing PERIOD=6 -> 6-cycle periods start the next cycle.
- Assert reset for 1 cycle mid-period in center mode -> pwm=0, period_tick=0 and counter=0 the following cycle; all shadow values are 0 and enable is 0.
